// File: rtl/warmup3_mpsubtractor.sv
// Multi-precision subtractor: result = A - B, one DIGIT-wide word per clock.
// Ports: clk, resetn (async low), start/in_a/in_b in; result (WIDTH+1) and done pulse out.
module warmup3_mpsubtractor #(
   parameter int WIDTH = 128,
   parameter int DIGIT = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH:0]   result,
   output logic             done
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [CW-1:0]    cnt;
   logic             borrow;
   logic [DIGIT:0]   d;

   // One extra bit: d[DIGIT] is set exactly when the digit difference is negative.
   always_comb begin
      d = {1'b0, a_sh[DIGIT-1:0]}
        - {1'b0, b_sh[DIGIT-1:0]}
        - {{DIGIT{1'b0}}, borrow};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         cnt    <= '0;
         borrow <= 1'b0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               // A start coinciding with the done pulse is dropped.
               if (start && !done) begin
                  a_sh   <= in_a;
                  b_sh   <= in_b;
                  cnt    <= '0;
                  borrow <= 1'b0;
                  state  <= RUN;
               end
            end
            RUN: begin
               done   <= 1'b0;
               a_sh   <= a_sh >> DIGIT;
               b_sh   <= b_sh >> DIGIT;
               borrow <= d[DIGIT];
               cnt    <= cnt + CW'(1);
               for (int i = 0; i < N; i++) begin
                  if (cnt == CW'(i)) begin
                     result[i*DIGIT +: DIGIT] <= d[DIGIT-1:0];
                  end
               end
               if (cnt == CW'(N - 1)) begin
                  result[WIDTH] <= d[DIGIT];
                  state         <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_warmup3_mpsubtractor.sv
// Scoreboard bench for warmup3_mpsubtractor: model pushes expected results,
// a monitor pops and compares on each done pulse, including latency.
module tb_warmup3_mpsubtractor;

   localparam int W = 128;
   localparam int N = 4;

   logic         clk;
   logic         resetn;
   logic         start;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [W:0]   result;
   logic         done;

   typedef struct {
      logic [W:0] r;
      int         e;
   } exp_t;

   exp_t q[$];
   int   edges;
   int   busy_until;
   int   ncheck;
   int   nfail;
   logic prev_done;

   warmup3_mpsubtractor #(.WIDTH(W), .DIGIT(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .in_a   (in_a),
      .in_b   (in_b),
      .result (result),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W:0] ref_sub(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      return {1'b0, a} - {1'b0, b};
   endfunction

   function automatic logic [W-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string nm, input logic [W:0] got,
                      input logic [W:0] exp);
      ncheck++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Monitor: runs 1 time unit after every rising edge.
   initial begin
      edges     = 0;
      prev_done = 1'b0;
      forever begin
         @(posedge clk);
         edges++;
         #1;
         if (resetn) begin
            while (q.size() > 0 && q[0].e < edges) begin
               ncheck++;
               nfail++;
               $display("FAIL missed_done: none at edge %0d expected edge %0d",
                        edges, q[0].e);
               void'(q.pop_front());
            end
            if (done) begin
               if (q.size() == 0) begin
                  ncheck++;
                  nfail++;
                  $display("FAIL unexpected_done: done=1 at edge %0d expected 0",
                           edges);
               end else begin
                  exp_t x;
                  x = q.pop_front();
                  chk("done_latency", (W+1)'(edges), (W+1)'(x.e));
                  chk("result", result, x.r);
               end
               if (prev_done) begin
                  ncheck++;
                  nfail++;
                  $display("FAIL done_width: done high 2 cycles, expected 1");
               end
            end
         end
         prev_done = done;
      end
   end

   // Drive one cycle of inputs; the model decides whether start is taken.
   task automatic edge_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic st);
      exp_t x;
      @(negedge clk);
      in_a  = a;
      in_b  = b;
      start = st;
      @(posedge clk);
      #2;
      if (st && resetn && edges > busy_until) begin
         x.r = ref_sub(a, b);
         x.e = edges + N + 1;
         q.push_back(x);
         busy_until = edges + N + 2;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start = 1'b0;
         in_a  = rnd128();
         in_b  = rnd128();
      end
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      resetn = 1'b0;
      start  = 1'b0;
      q.delete();
      #1;
      chk({nm, "_result"}, result, '0);
      chk({nm, "_done"}, (W+1)'(done), '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn     = 1'b1;
      busy_until = edges;
   endtask

   logic [W-1:0] t1a, t1b, t4a, t4b, eq;

   initial begin
      ncheck     = 0;
      nfail      = 0;
      busy_until = -1;
      start      = 1'b0;
      in_a       = '0;
      in_b       = '0;
      resetn     = 1'b0;
      t1a = 128'hcbc87cf0da4497687834fad762e4fa0d;
      t1b = 128'h88f32f2f5b948a6ccf335529fa86ee6c;
      t4a = 128'h00000001_00000000_00000000_00000000;
      t4b = 128'h1;
      eq  = 128'h0123456789abcdef0123456789abcdef;
      #1;
      chk("reset_result", result, '0);
      chk("reset_done", (W+1)'(done), '0);
      idle(2);
      resetn     = 1'b1;
      busy_until = edges;
      idle(1);

      edge_start(t1a, t1b, 1'b1);
      idle(8);
      edge_start(t1b, t1a, 1'b1);
      idle(8);
      edge_start('0, 128'h1, 1'b1);
      idle(8);
      edge_start(eq, eq, 1'b1);
      idle(8);
      edge_start(t4a, t4b, 1'b1);
      idle(8);

      // Second start while busy must be ignored.
      edge_start(t1a, t1b, 1'b1);
      idle(1);
      edge_start(t4a, t4b, 1'b1);
      idle(8);
      edge_start(t1b, t1a, 1'b1);
      idle(8);

      // Reset mid-operation: no done follows.
      edge_start(t1a, t1b, 1'b1);
      idle(2);
      do_reset("midrst");
      idle(10);
      edge_start(t4a, t4b, 1'b1);
      idle(8);

      // Start held high: accepted at each return to IDLE.
      for (int i = 0; i < 20; i++) begin
         edge_start(rnd128(), rnd128(), 1'b1);
      end
      idle(8);

      // Random operands, random gaps, occasional starts while busy.
      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] a, b;
         a = rnd128();
         b = rnd128();
         case ($urandom_range(0, 3))
            0: b = a;
            1: a = '0;
            default: ;
         endcase
         edge_start(a, b, 1'b1);
         idle($urandom_range(0, 7));
      end

      idle(12);
      ncheck++;
      if (q.size() != 0) begin
         nfail++;
         $display("FAIL pending: %0d results outstanding, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               ncheck, nfail);
      $finish;
   end

endmodule
